// File: rtl/seq_pkg.sv
// Shared constants for the serial sequence link: transmitter state encoding and the
// default pattern the detector benches look for.
package seq_pkg;

   localparam logic [1:0] SEQ_ST_IDLE = 2'd0;
   localparam logic [1:0] SEQ_ST_SEND = 2'd1;
   localparam logic [1:0] SEQ_ST_GAP  = 2'd2;
   localparam logic [1:0] SEQ_ST_DONE = 2'd3;

   localparam int unsigned SEQ_PAT_W   = 4;
   localparam logic [3:0]  SEQ_PATTERN = 4'b1001;

   typedef enum logic [1:0] {
      StIdle = SEQ_ST_IDLE,
      StSend = SEQ_ST_SEND,
      StGap  = SEQ_ST_GAP,
      StDone = SEQ_ST_DONE
   } seq_state_e;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module seq_down_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: on start, sends PATTERN MSB-first rep_count times with a
// programmable idle gap between copies. All outputs are registered.
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int unsigned     PAT_W   = SEQ_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQ_PATTERN),
   parameter int unsigned     CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_rep_count,
   input  logic [CNT_W-1:0] i_gap,
   output logic             o_ser_out,
   output logic             o_ser_valid,
   output logic             o_frame_end,
   output logic             o_busy,
   output logic             o_done
);

   localparam int unsigned     IDX_W   = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

   seq_state_e       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;
   logic [CNT_W-1:0] r_gap, w_gap_nxt;

   logic             w_copy_load, w_copy_dec, w_copy_last;
   logic [CNT_W-1:0] w_copy_val;
   logic             w_gap_load, w_gap_dec, w_gap_zero;
   logic [CNT_W-1:0] w_gap_val;

   logic w_ser_out_nxt, w_ser_valid_nxt, w_frame_end_nxt, w_busy_nxt, w_done_nxt;

   // Copy counter holds copies remaining after the current one, so zero marks the last.
   seq_down_cnt #(
      .CNT_W (CNT_W)
   ) u_copy_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_copy_load),
      .i_load_val (w_copy_val),
      .i_dec      (w_copy_dec),
      .o_zero     (w_copy_last)
   );

   // Gap counter holds idle cycles remaining after the current one.
   seq_down_cnt #(
      .CNT_W (CNT_W)
   ) u_gap_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_gap_load),
      .i_load_val (w_gap_val),
      .i_dec      (w_gap_dec),
      .o_zero     (w_gap_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_idx   <= '0;
         r_gap   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_gap   <= w_gap_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_gap_nxt   = r_gap;
      w_copy_load = 1'b0;
      w_copy_val  = '0;
      w_copy_dec  = 1'b0;
      w_gap_load  = 1'b0;
      w_gap_val   = '0;
      w_gap_dec   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_start && (i_rep_count != '0)) begin
               w_state_nxt = StSend;
               w_idx_nxt   = IDX_TOP;
               w_gap_nxt   = i_gap;
               w_copy_load = 1'b1;
               w_copy_val  = i_rep_count - 1'b1;
            end
         end
         StSend: begin
            if (r_idx != '0) begin
               w_idx_nxt = r_idx - 1'b1;
            end else if (w_copy_last) begin
               w_state_nxt = StDone;
            end else begin
               w_copy_dec = 1'b1;
               w_idx_nxt  = IDX_TOP;
               if (r_gap != '0) begin
                  w_state_nxt = StGap;
                  w_gap_load  = 1'b1;
                  w_gap_val   = r_gap - 1'b1;
               end
            end
         end
         StGap: begin
            if (w_gap_zero) begin
               w_state_nxt = StSend;
            end else begin
               w_gap_dec = 1'b1;
            end
         end
         StDone: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase

      // Outputs describe the cycle after the edge, keeping them purely registered.
      w_ser_valid_nxt = (w_state_nxt == StSend);
      w_ser_out_nxt   = w_ser_valid_nxt && PATTERN[w_idx_nxt];
      w_frame_end_nxt = w_ser_valid_nxt && (w_idx_nxt == '0);
      w_busy_nxt      = (w_state_nxt != StIdle);
      w_done_nxt      = (w_state_nxt == StDone);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         o_ser_out   <= 1'b0;
         o_ser_valid <= 1'b0;
         o_frame_end <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         o_ser_out   <= w_ser_out_nxt;
         o_ser_valid <= w_ser_valid_nxt;
         o_frame_end <= w_frame_end_nxt;
         o_busy      <= w_busy_nxt;
         o_done      <= w_done_nxt;
      end
   end

endmodule
